// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the single D$ request port between the MEM
// stage (port 0) and the page-table walker (port 1). One owner at a time,
// grant held until the owner drops its request, and a forced idle gap
// between owners so the D$ always sees a fresh request assertion.
module dcache_port_arbiter #(
    parameter int FIXED_PRIO = 0,    // 0: round-robin, 1: PTW wins ties
    parameter int TIMEOUT    = 1024  // OWN cycles without done before timeout_err
) (
    input  logic        clk,
    input  logic        reset,

    // port 0: MEM stage
    input  logic        mem_en,
    input  logic [63:0] mem_addr,
    input  logic        mem_write_en,
    input  logic [63:0] mem_wdata,
    input  logic [1:0]  mem_wlen,
    output logic        mem_gnt,
    output logic [63:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        mem_write_done,

    // port 1: page-table walker
    input  logic        ptw_en,
    input  logic [63:0] ptw_addr,
    input  logic        ptw_write_en,
    input  logic [63:0] ptw_wdata,
    input  logic [1:0]  ptw_wlen,
    output logic        ptw_gnt,
    output logic [63:0] ptw_rdata,
    output logic        ptw_rvalid,
    output logic        ptw_write_done,

    // shared D$ request port
    output logic        dc_en,
    output logic [63:0] dc_in_addr,
    output logic        dc_write_en,
    output logic [63:0] dc_in_wdata,
    output logic [1:0]  dc_in_wlen,
    input  logic [63:0] dc_out_rdata,
    input  logic        dc_out_rvalid,
    input  logic        dc_out_write_done,

    output logic        timeout_err
);

    localparam int          NUM_PORTS = 2;
    localparam bit          PRIO_PTW  = (FIXED_PRIO != 0);
    localparam logic [31:0] TMO       = TIMEOUT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      state;
    logic        last;   // last owner; 1 out of reset so port 0 wins the first tie
    logic [15:0] cnt;    // OWN cycles since grant or last done

    // requests gathered into per-port arrays, index 0 = MEM, 1 = PTW
    logic [NUM_PORTS-1:0]       req_en;
    logic [NUM_PORTS-1:0]       req_we;
    logic [NUM_PORTS-1:0][63:0] req_addr;
    logic [NUM_PORTS-1:0][63:0] req_wdata;
    logic [NUM_PORTS-1:0][1:0]  req_wlen;
    logic [NUM_PORTS-1:0]       own;
    logic [NUM_PORTS-1:0]       rvalid;
    logic [NUM_PORTS-1:0]       wdone;

    assign req_en    = {ptw_en, mem_en};
    assign req_we    = {ptw_write_en, mem_write_en};
    assign req_addr  = {ptw_addr, mem_addr};
    assign req_wdata = {ptw_wdata, mem_wdata};
    assign req_wlen  = {ptw_wlen, mem_wlen};

    // the registered grants are the one-hot owner vector
    assign own = {ptw_gnt, mem_gnt};

    // Responses go only to the current owner, and only while it still
    // requests; anything arriving in IDLE/GAP or after an abort is dropped.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign rvalid[p] = dc_out_rvalid     & own[p] & req_en[p];
        assign wdone[p]  = dc_out_write_done & own[p] & req_en[p];
    end

    assign mem_rvalid     = rvalid[0];
    assign ptw_rvalid     = rvalid[1];
    assign mem_write_done = wdone[0];
    assign ptw_write_done = wdone[1];

    // read data is broadcast; consumers qualify it with their rvalid
    assign mem_rdata = dc_out_rdata;
    assign ptw_rdata = dc_out_rdata;

    // Arbitration in IDLE: a lone requester wins; on a tie PTW wins under
    // fixed priority, otherwise whichever port did not own the bus last.
    logic pick0, pick1;
    assign pick1 = ptw_en & (~mem_en | PRIO_PTW | ~last);
    assign pick0 = mem_en & ~pick1;

    // watchdog: any owner response restarts the count
    logic        done;
    logic [15:0] cnt_sat;
    logic        cnt_hit;
    assign done    = |(rvalid | wdone);
    assign cnt_sat = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign cnt_hit = ({16'd0, cnt_sat} >= TMO);

    // Steer the owner's request to the D$ unregistered; zero when unowned.
    always_comb begin
        dc_en       = 1'b0;
        dc_in_addr  = '0;
        dc_write_en = 1'b0;
        dc_in_wdata = '0;
        dc_in_wlen  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (own[p]) begin
                dc_en       = req_en[p];
                dc_in_addr  = req_addr[p];
                dc_write_en = req_we[p];
                dc_in_wdata = req_wdata[p];
                dc_in_wlen  = req_wlen[p];
            end
        end
    end

    // Ownership FSM with registered grants, last-owner bit and watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            cnt         <= '0;
            timeout_err <= 1'b0;
            mem_gnt     <= 1'b0;
            ptw_gnt     <= 1'b0;
        end else begin
            // count only while someone owns the port; the counter sits at
            // zero elsewhere so every new grant starts from a clean count
            if (state == OWN0 || state == OWN1) begin
                if (done) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_sat;
                    if (cnt_hit)
                        timeout_err <= 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (pick0) begin
                        state   <= OWN0;
                        mem_gnt <= 1'b1;
                    end else if (pick1) begin
                        state   <= OWN1;
                        ptw_gnt <= 1'b1;
                    end
                end
                // the MEM stage keeps en high past done until it advances,
                // so ownership ends only on the request falling
                OWN0: begin
                    if (!mem_en) begin
                        state   <= GAP;
                        last    <= 1'b0;
                        mem_gnt <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!ptw_en) begin
                        state   <= GAP;
                        last    <= 1'b1;
                        ptw_gnt <= 1'b0;
                    end
                end
                // one dead cycle so dc_en never stays high across owners
                GAP: state <= IDLE;
                default: begin
                    state   <= IDLE;
                    mem_gnt <= 1'b0;
                    ptw_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a per-cycle vector table for the
// main flows plus hand sequences for timeout, fixed priority and mid-grant
// reset. One round-robin instance and one fixed-priority instance share the
// same stimulus; both use TIMEOUT=8.
module tb_dcache_port_arbiter;

    localparam logic [63:0] MEM_ADDR  = 64'h1000;
    localparam logic [63:0] PTW_ADDR  = 64'h2000;
    localparam logic [63:0] MEM_WDATA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] PTW_WDATA = 64'h5555_6666_7777_8888;
    localparam logic [1:0]  MEM_WLEN  = 2'd3;
    localparam logic [1:0]  PTW_WLEN  = 2'd2;
    localparam logic        MEM_WE    = 1'b0;
    localparam logic        PTW_WE    = 1'b1;
    localparam logic [63:0] RDATA     = 64'hDEAD;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_en, ptw_en;
    logic [63:0] mem_addr, ptw_addr, mem_wdata, ptw_wdata;
    logic        mem_write_en, ptw_write_en;
    logic [1:0]  mem_wlen, ptw_wlen;
    logic [63:0] dc_out_rdata;
    logic        dc_out_rvalid, dc_out_write_done;

    // round-robin instance outputs
    logic        r_mem_gnt, r_ptw_gnt, r_mem_rvalid, r_ptw_rvalid;
    logic        r_mem_wd, r_ptw_wd, r_dc_en, r_dc_we, r_terr;
    logic [63:0] r_mem_rdata, r_ptw_rdata, r_dc_addr, r_dc_wdata;
    logic [1:0]  r_dc_wlen;
    // fixed-priority instance outputs
    logic        f_mem_gnt, f_ptw_gnt, f_mem_rvalid, f_ptw_rvalid;
    logic        f_mem_wd, f_ptw_wd, f_dc_en, f_dc_we, f_terr;
    logic [63:0] f_mem_rdata, f_ptw_rdata, f_dc_addr, f_dc_wdata;
    logic [1:0]  f_dc_wlen;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset(reset),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
        .mem_gnt(r_mem_gnt), .mem_rdata(r_mem_rdata), .mem_rvalid(r_mem_rvalid),
        .mem_write_done(r_mem_wd),
        .ptw_en(ptw_en), .ptw_addr(ptw_addr), .ptw_write_en(ptw_write_en),
        .ptw_wdata(ptw_wdata), .ptw_wlen(ptw_wlen),
        .ptw_gnt(r_ptw_gnt), .ptw_rdata(r_ptw_rdata), .ptw_rvalid(r_ptw_rvalid),
        .ptw_write_done(r_ptw_wd),
        .dc_en(r_dc_en), .dc_in_addr(r_dc_addr), .dc_write_en(r_dc_we),
        .dc_in_wdata(r_dc_wdata), .dc_in_wlen(r_dc_wlen),
        .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid),
        .dc_out_write_done(dc_out_write_done),
        .timeout_err(r_terr)
    );

    dcache_port_arbiter #(.FIXED_PRIO(1), .TIMEOUT(8)) u_fp (
        .clk(clk), .reset(reset),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
        .mem_gnt(f_mem_gnt), .mem_rdata(f_mem_rdata), .mem_rvalid(f_mem_rvalid),
        .mem_write_done(f_mem_wd),
        .ptw_en(ptw_en), .ptw_addr(ptw_addr), .ptw_write_en(ptw_write_en),
        .ptw_wdata(ptw_wdata), .ptw_wlen(ptw_wlen),
        .ptw_gnt(f_ptw_gnt), .ptw_rdata(f_ptw_rdata), .ptw_rvalid(f_ptw_rvalid),
        .ptw_write_done(f_ptw_wd),
        .dc_en(f_dc_en), .dc_in_addr(f_dc_addr), .dc_write_en(f_dc_we),
        .dc_in_wdata(f_dc_wdata), .dc_in_wlen(f_dc_wlen),
        .dc_out_rdata(dc_out_rdata), .dc_out_rvalid(dc_out_rvalid),
        .dc_out_write_done(dc_out_write_done),
        .timeout_err(f_terr)
    );

    // in  = {reset, mem_en, ptw_en, dc_out_rvalid, dc_out_write_done}
    // exp = {mem_gnt, ptw_gnt, dc_en, mem_rvalid, ptw_rvalid, mem_wd, ptw_wd}
    typedef struct {
        logic [4:0] in;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] in, input logic [6:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // inputs change 1ns after the edge; outputs are sampled on the falling edge
    task automatic drive(input logic [4:0] in);
        @(posedge clk);
        #1;
        {reset, mem_en, ptw_en, dc_out_rvalid, dc_out_write_done} = in;
        #4;
    endtask

    initial begin
        reset = 1'b1; mem_en = 1'b0; ptw_en = 1'b0;
        dc_out_rvalid = 1'b0; dc_out_write_done = 1'b0;
        dc_out_rdata = RDATA;
        mem_addr = MEM_ADDR; mem_write_en = MEM_WE; mem_wdata = MEM_WDATA; mem_wlen = MEM_WLEN;
        ptw_addr = PTW_ADDR; ptw_write_en = PTW_WE; ptw_wdata = PTW_WDATA; ptw_wlen = PTW_WLEN;

        // reset state
        add(5'b00000, 7'b0000000);
        // single MEM read: grant at c1, write_done at c2, rvalid at c3, drop c4
        add(5'b01000, 7'b0000000);
        add(5'b01000, 7'b1010000);
        add(5'b01001, 7'b1010010);
        add(5'b01010, 7'b1011000);
        add(5'b00000, 7'b1000000);
        add(5'b00000, 7'b0000000);
        add(5'b00000, 7'b0000000);
        // simultaneous after reset: MEM at c1, drop c5, GAP c6, IDLE c7, PTW c8
        add(5'b10000, 7'b0000000);
        add(5'b01100, 7'b0000000);
        add(5'b01100, 7'b1010000);
        add(5'b01100, 7'b1010000);
        add(5'b01100, 7'b1010000);
        add(5'b01100, 7'b1010000);
        add(5'b00100, 7'b1000000);
        add(5'b00100, 7'b0000000);
        add(5'b00100, 7'b0000000);
        add(5'b00100, 7'b0110000);
        add(5'b00000, 7'b0100000);
        add(5'b00000, 7'b0000000);
        // round-robin with both re-requesting: owners 0,1,0,1
        add(5'b01100, 7'b0000000);
        add(5'b01110, 7'b1011000);
        add(5'b00100, 7'b1000000);
        add(5'b01100, 7'b0000000);
        add(5'b01100, 7'b0000000);
        add(5'b01101, 7'b0110001);
        add(5'b01000, 7'b0100000);
        add(5'b01100, 7'b0000000);
        add(5'b01100, 7'b0000000);
        add(5'b01100, 7'b1010000);
        add(5'b00100, 7'b1000000);
        add(5'b01100, 7'b0000000);
        add(5'b01100, 7'b0000000);
        add(5'b01100, 7'b0110000);
        add(5'b01000, 7'b0100000);
        add(5'b00000, 7'b0000000);
        add(5'b00000, 7'b0000000);
        // abort: MEM drops before done; late responses in drop/GAP/IDLE are discarded
        add(5'b01000, 7'b0000000);
        add(5'b01000, 7'b1010000);
        add(5'b00010, 7'b1000000);
        add(5'b00011, 7'b0000000);
        add(5'b00110, 7'b0000000);
        add(5'b00100, 7'b0110000);
        add(5'b00000, 7'b0100000);
        add(5'b00000, 7'b0000000);
        add(5'b00000, 7'b0000000);

        drive(5'b10000);
        drive(5'b10000);

        foreach (tbl[i]) begin
            logic        g0, g1;
            logic [63:0] ea, ed;
            logic        ew;
            logic [1:0]  el;
            drive(tbl[i].in);
            g0 = tbl[i].exp[6];
            g1 = tbl[i].exp[5];
            ea = g0 ? MEM_ADDR  : g1 ? PTW_ADDR  : 64'd0;
            ed = g0 ? MEM_WDATA : g1 ? PTW_WDATA : 64'd0;
            ew = g0 ? MEM_WE    : g1 ? PTW_WE    : 1'b0;
            el = g0 ? MEM_WLEN  : g1 ? PTW_WLEN  : 2'd0;
            chk($sformatf("v%0d mem_gnt", i),    64'(r_mem_gnt),    64'(g0));
            chk($sformatf("v%0d ptw_gnt", i),    64'(r_ptw_gnt),    64'(g1));
            chk($sformatf("v%0d dc_en", i),      64'(r_dc_en),      64'(tbl[i].exp[4]));
            chk($sformatf("v%0d mem_rvalid", i), 64'(r_mem_rvalid), 64'(tbl[i].exp[3]));
            chk($sformatf("v%0d ptw_rvalid", i), 64'(r_ptw_rvalid), 64'(tbl[i].exp[2]));
            chk($sformatf("v%0d mem_wdone", i),  64'(r_mem_wd),     64'(tbl[i].exp[1]));
            chk($sformatf("v%0d ptw_wdone", i),  64'(r_ptw_wd),     64'(tbl[i].exp[0]));
            chk($sformatf("v%0d dc_in_addr", i), r_dc_addr,         ea);
            chk($sformatf("v%0d dc_in_wdata", i), r_dc_wdata,       ed);
            chk($sformatf("v%0d dc_write_en", i), 64'(r_dc_we),     64'(ew));
            chk($sformatf("v%0d dc_in_wlen", i), 64'(r_dc_wlen),    64'(el));
            chk($sformatf("v%0d timeout_err", i), 64'(r_terr),      64'd0);
            chk($sformatf("v%0d mem_rdata", i),  r_mem_rdata,       RDATA);
            chk($sformatf("v%0d ptw_rdata", i),  r_ptw_rdata,       RDATA);
        end

        // timeout: a done in OWN cycle 6 restarts the count, so the flag
        // sets only after OWN cycles 7..14 with no response (visible in 15)
        drive(5'b10000);
        drive(5'b01000);
        for (int k = 1; k <= 15; k++) begin
            drive((k == 6) ? 5'b01010 : 5'b01000);
            chk($sformatf("tmo own%0d mem_gnt", k), 64'(r_mem_gnt), 64'd1);
            chk($sformatf("tmo own%0d timeout_err", k), 64'(r_terr), 64'(k == 15));
        end
        drive(5'b00000);
        chk("tmo drop sticky", 64'(r_terr), 64'd1);
        drive(5'b00000);
        chk("tmo gap sticky", 64'(r_terr), 64'd1);
        drive(5'b00000);
        chk("tmo idle sticky", 64'(r_terr), 64'd1);
        drive(5'b10000);
        chk("tmo reset cycle", 64'(r_terr), 64'd1);
        drive(5'b00000);
        chk("tmo after reset", 64'(r_terr), 64'd0);

        // fixed priority: PTW keeps re-requesting and owns every transaction
        drive(5'b10000);
        for (int t = 0; t < 4; t++) begin
            drive(5'b01100);
            chk($sformatf("fp t%0d idle ptw_gnt", t), 64'(f_ptw_gnt), 64'd0);
            chk($sformatf("fp t%0d idle mem_gnt", t), 64'(f_mem_gnt), 64'd0);
            drive(5'b01100);
            chk($sformatf("fp t%0d ptw_gnt", t), 64'(f_ptw_gnt), 64'd1);
            chk($sformatf("fp t%0d mem_gnt", t), 64'(f_mem_gnt), 64'd0);
            chk($sformatf("fp t%0d dc_en", t), 64'(f_dc_en), 64'd1);
            chk($sformatf("fp t%0d dc_in_addr", t), f_dc_addr, PTW_ADDR);
            drive(5'b01000);
            chk($sformatf("fp t%0d drop ptw_gnt", t), 64'(f_ptw_gnt), 64'd1);
            chk($sformatf("fp t%0d drop dc_en", t), 64'(f_dc_en), 64'd0);
            drive(5'b01100);
            chk($sformatf("fp t%0d gap ptw_gnt", t), 64'(f_ptw_gnt), 64'd0);
            chk($sformatf("fp t%0d gap dc_en", t), 64'(f_dc_en), 64'd0);
        end

        // reset in OWN1 with last=0: outputs clear next cycle, tie goes to MEM
        drive(5'b10000);
        drive(5'b01000);
        drive(5'b01000);
        chk("rst pre mem_gnt", 64'(r_mem_gnt), 64'd1);
        drive(5'b00100);
        drive(5'b00100);
        drive(5'b00100);
        drive(5'b00100);
        chk("rst own1 ptw_gnt", 64'(r_ptw_gnt), 64'd1);
        drive(5'b11110);
        chk("rst cycle ptw_gnt", 64'(r_ptw_gnt), 64'd1);
        drive(5'b01110);
        chk("rst after mem_gnt", 64'(r_mem_gnt), 64'd0);
        chk("rst after ptw_gnt", 64'(r_ptw_gnt), 64'd0);
        chk("rst after dc_en", 64'(r_dc_en), 64'd0);
        chk("rst after dc_in_addr", r_dc_addr, 64'd0);
        chk("rst after dc_in_wdata", r_dc_wdata, 64'd0);
        chk("rst after mem_rvalid", 64'(r_mem_rvalid), 64'd0);
        chk("rst after ptw_rvalid", 64'(r_ptw_rvalid), 64'd0);
        chk("rst after timeout_err", 64'(r_terr), 64'd0);
        drive(5'b01100);
        chk("rst tie mem_gnt", 64'(r_mem_gnt), 64'd1);
        chk("rst tie ptw_gnt", 64'(r_ptw_gnt), 64'd0);
        chk("rst tie dc_in_addr", r_dc_addr, MEM_ADDR);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
